// File: rtl/tsr_pkg.sv
// tsr_pkg: shared register map, FSM encoding and status field layout for the test status reporter.
package tsr_pkg;
    localparam logic [3:0] REG_STAGE = 4'h0;
    localparam logic [3:0] REG_ERROR = 4'h4;
    localparam logic [3:0] REG_CTRL  = 4'h8;
    localparam logic [3:0] REG_RSVD  = 4'hC;
    localparam int STAGE_W  = 5;
    localparam int ERR_BIT  = 5;
    localparam int STATUS_W = 6;
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } tsr_state_e;
endpackage

// File: rtl/tsr_fifo.sv
// tsr_fifo: synchronous stage-code queue with push/pop/flush and full/empty/count flags.
module tsr_fifo
    import tsr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = STAGE_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW   = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH) + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [CNTW-1:0]  cnt_q;
    logic             do_push, do_pop;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction
    // A full queue still accepts a push when the head leaves in the same cycle
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
    assign full_o  = cnt_q == CNTW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= inc(wr_q);
            if (do_pop) rd_q <= inc(rd_q);
            cnt_q <= cnt_q + CNTW'(do_push) - CNTW'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/test_status_reporter.sv
// test_status_reporter: Wishbone slave that queues test stage codes and holds each on the status pins
// long enough for a slow external monitor to sample it.
module test_status_reporter
    import tsr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          HOLD_CYCLES = 128,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [STATUS_W-1:0] status_o,
    output logic [STATUS_W-1:0] status_oeb_o
);
    localparam int CW   = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    logic               req, wr, push, pop, flush, full, empty;
    logic [3:0]         off;
    logic [CNTW-1:0]    count;
    logic [STAGE_W-1:0] head, stage_q;
    logic               ack_q, error_q, oe_q, overflow_q;
    logic [31:0]        dat_q, rdata;
    tsr_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               unused_ok;
    assign unused_ok = &{1'b0, wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:5]};
    assign req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
    assign off   = {wbs_adr_i[3:2], 2'b00};
    assign wr    = req & wbs_we_i & wbs_sel_i[0];
    assign push  = wr & (off == REG_STAGE);
    assign flush = wr & (off == REG_CTRL) & wbs_dat_i[1];
    assign pop   = (state_q == ST_IDLE) & ~empty & ~flush;
    assign rdata = off == REG_STAGE ? {12'h0, 8'(count), 4'h0, overflow_q, full, empty, stage_q}
                 : off == REG_ERROR ? {31'h0, error_q}
                 : off == REG_CTRL  ? {31'h0, oe_q}
                 : 32'h0;
    tsr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(STAGE_W)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (wbs_dat_i[STAGE_W-1:0]),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (pop) begin
                state_d = ST_HOLD;
                cnt_d   = CW'(HOLD_CYCLES - 1);
            end
        end else if (cnt_q == '0) begin
            state_d = ST_IDLE;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            stage_q    <= '0;
            error_q    <= 1'b0;
            oe_q       <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
        end else begin
            ack_q   <= req;
            dat_q   <= (req & ~wbs_we_i) ? rdata : '0;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) stage_q <= head;
            if (wr & (off == REG_ERROR) & wbs_dat_i[0]) error_q <= 1'b1;
            if (wr & (off == REG_CTRL)) oe_q <= wbs_dat_i[0];
            // Overflow marks a dropped push; a simultaneous pop makes room so nothing is lost
            if (flush) overflow_q <= 1'b0;
            else if (push & full & ~pop) overflow_q <= 1'b1;
        end
    end
    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign status_o     = {error_q, stage_q};
    assign status_oeb_o = {STATUS_W{~oe_q}};
endmodule

// File: tb/tb_test_status_reporter.sv
// tb_test_status_reporter: randomized and directed checks of test_status_reporter against a queue-based model.
module tb_test_status_reporter;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int HOLD  = 128;
    localparam int DEPTH = 4;
    logic        clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0, dat_o;
    logic        ack;
    logic [5:0]  status, oeb;
    int vectors = 0, miscompares = 0;

    test_status_reporter #(.BASE_ADDR(BASE), .HOLD_CYCLES(HOLD), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .status_o(status), .status_oeb_o(oeb)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of stage codes and the edge at which the last one was shown
    int          mq[$];
    logic [4:0]  m_stage;
    logic        m_err, m_oe, m_ovf, m_ack;
    logic [31:0] m_dat;
    longint      cyc_n = 0, m_last = -1000000;
    logic        m_commit, m_wr, m_flush, m_pop, m_full;
    logic [3:0]  m_off;
    logic [5:0]  m_status, m_oeb;
    assign m_status = {m_err, m_stage};
    assign m_oeb    = {6{~m_oe}};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_stage = 0; m_err = 0; m_oe = 0; m_ovf = 0; m_ack = 0; m_dat = 0;
            m_last = -1000000;
            if (clk) cyc_n++;
        end else begin
            cyc_n++;
            m_commit = cyc && stb && (adr[31:4] == BASE[31:4]) && !m_ack;
            m_off    = {adr[3:2], 2'b00};
            m_wr     = m_commit && we && sel[0];
            m_dat    = 0;
            if (m_commit && !we)
                m_dat = m_off == 4'h0 ? {12'h0, 8'(mq.size()), 4'h0, m_ovf, mq.size() == DEPTH, mq.size() == 0, m_stage}
                      : m_off == 4'h4 ? {31'h0, m_err}
                      : m_off == 4'h8 ? {31'h0, m_oe} : 32'h0;
            m_ack   = m_commit;
            m_flush = m_wr && m_off == 4'h8 && wdat[1];
            m_full  = mq.size() == DEPTH;
            m_pop   = !m_flush && mq.size() > 0 && cyc_n >= m_last + HOLD + 1;
            if (m_pop) begin
                m_stage = 5'(mq.pop_front());
                m_last  = cyc_n;
            end
            if (m_flush) begin
                mq.delete();
                m_ovf = 0;
            end
            if (m_wr && m_off == 4'h0) begin
                if (m_full && !m_pop) m_ovf = 1;
                else mq.push_back(int'(wdat[4:0]));
            end
            if (m_wr && m_off == 4'h4 && wdat[0]) m_err = 1;
            if (m_wr && m_off == 4'h8) m_oe = wdat[0];
        end
    end

    // Passive recorder of status_o changes with their edge index
    logic [5:0] chg_v[$];
    longint     chg_t[$];
    logic [5:0] last_st = 6'h00;
    always @(negedge clk) begin
        if (status !== last_st) begin
            chg_v.push_back(status);
            chg_t.push_back(cyc_n);
            last_st = status;
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic got);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s; got = 0; rd = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = ack;
            if (got) rd = dat_o;
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (status !== 6'h00) begin miscompares++; $display("FAIL reset_status got %h exp 00", status); end
        vectors++; if (oeb !== 6'h3F) begin miscompares++; $display("FAIL reset_oeb got %h exp 3f", oeb); end
        vectors++; if (ack !== 1'b0 || dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_bus got ack=%b dat=%h exp 0/0", ack, dat_o); end
        rst = 0;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic got, seen;
        bus(1, BASE + 8, 32'h1, 4'hF, rd, got);
        vectors++; if (got !== 1'b1 || oeb !== 6'h00) begin miscompares++; $display("FAIL basic_oe got ack=%b oeb=%h exp 1/00", got, oeb); end
        bus(1, BASE, 32'd31, 4'hF, rd, got);
        seen = 0;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge clk);
            seen = status === 6'h1F;
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL basic_stage got %h exp 1f within 3 cycles", status); end
    endtask

    task automatic test_hold_timing();
        logic [31:0] rd; logic got, s1f, s1e; int bad; longint held;
        do_reset();
        bus(1, BASE + 8, 32'h1, 4'hF, rd, got);
        chg_v.delete(); chg_t.delete();
        bus(1, BASE, 32'd31, 4'hF, rd, got);
        bus(1, BASE, 32'd30, 4'hF, rd, got);
        s1f = 0; s1e = 0; bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (status !== m_status) bad++;
            if (cyc_n % 100 == 0) begin
                if (status === 6'h1F) s1f = 1;
                if (status === 6'h1E) s1e = 1;
            end
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL hold_model got %0d divergent cycles exp 0", bad); end
        vectors++;
        if (chg_v.size() < 2 || chg_v[0] !== 6'h1F || chg_v[1] !== 6'h1E) begin
            miscompares++; $display("FAIL hold_sequence got %0d changes exp 1f then 1e", chg_v.size());
        end else begin
            held = chg_t[1] - chg_t[0];
            vectors++; if (held != HOLD + 1) begin miscompares++; $display("FAIL hold_length got %0d exp %0d", held, HOLD + 1); end
        end
        vectors++; if (!(s1f && s1e)) begin miscompares++; $display("FAIL hold_monitor got 1f=%b 1e=%b exp 1/1", s1f, s1e); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd; logic got, all_got;
        do_reset();
        bus(1, BASE + 8, 32'h1, 4'hF, rd, got);
        bus(1, BASE, 32'd9, 4'hF, rd, got);
        repeat (3) @(negedge clk);
        all_got = 1;
        for (int v = 1; v <= 5; v++) begin
            bus(1, BASE, 32'(v), 4'hF, rd, got);
            all_got &= got;
        end
        vectors++; if (!all_got) begin miscompares++; $display("FAIL ovf_acks got missing ack exp all acked"); end
        bus(0, BASE, 32'h0, 4'hF, rd, got);
        vectors++; if (rd !== 32'h0000_40C9) begin miscompares++; $display("FAIL ovf_stage_reg got %h exp 000040c9", rd); end
        chg_v.delete(); chg_t.delete();
        repeat (4 * (HOLD + 1) + 20) @(negedge clk);
        vectors++;
        if (chg_v.size() != 4) begin
            miscompares++; $display("FAIL ovf_seq_len got %0d exp 4", chg_v.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (chg_v[i] !== 6'(i + 1)) begin miscompares++; $display("FAIL ovf_seq[%0d] got %h exp %h", i, chg_v[i], 6'(i + 1)); end
            end
        end
    endtask

    task automatic test_error();
        logic [31:0] rd; logic got, found;
        do_reset();
        bus(1, BASE + 8, 32'h1, 4'hF, rd, got);
        bus(1, BASE, 32'd3, 4'hF, rd, got);
        bus(1, BASE, 32'd6, 4'hF, rd, got);
        repeat (5) @(negedge clk);
        bus(1, BASE + 4, 32'h1, 4'hF, rd, got);
        vectors++; if (status !== 6'h23) begin miscompares++; $display("FAIL err_set got %h exp 23", status); end
        bus(1, BASE + 4, 32'h0, 4'hF, rd, got);
        vectors++; if (status !== 6'h23) begin miscompares++; $display("FAIL err_sticky got %h exp 23", status); end
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            found = status[4:0] === 5'd6;
        end
        vectors++; if (status !== 6'h26) begin miscompares++; $display("FAIL err_next_stage got %h exp 26", status); end
        bus(0, BASE + 4, 32'h0, 4'hF, rd, got);
        vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL err_reg got %h exp 00000001", rd); end
    endtask

    task automatic test_flush();
        logic [31:0] rd; logic got;
        do_reset();
        bus(1, BASE + 8, 32'h1, 4'hF, rd, got);
        bus(1, BASE, 32'd7, 4'hF, rd, got);
        repeat (3) @(negedge clk);
        bus(1, BASE, 32'd8, 4'hF, rd, got);
        for (int v = 1; v <= 4; v++) bus(1, BASE, 32'(v), 4'hF, rd, got);
        bus(0, BASE, 32'h0, 4'hF, rd, got);
        vectors++; if (rd !== 32'h0000_40C7) begin miscompares++; $display("FAIL flush_pre got %h exp 000040c7", rd); end
        bus(1, BASE + 8, 32'h3, 4'hF, rd, got);
        bus(0, BASE, 32'h0, 4'hF, rd, got);
        vectors++; if (rd !== 32'h0000_0027) begin miscompares++; $display("FAIL flush_reg got %h exp 00000027", rd); end
        chg_v.delete(); chg_t.delete();
        repeat (300) @(negedge clk);
        vectors++; if (chg_v.size() != 0 || status !== 6'h07 || oeb !== 6'h00) begin
            miscompares++; $display("FAIL flush_hold got changes=%0d status=%h oeb=%h exp 0/07/00", chg_v.size(), status, oeb);
        end
    endtask

    task automatic test_bus_misc();
        logic [31:0] rd; logic got;
        do_reset();
        bus(1, BASE + 8, 32'h1, 4'hF, rd, got);
        bus(1, BASE, 32'd5, 4'hE, rd, got);
        repeat (3) @(negedge clk);
        vectors++; if (got !== 1'b1 || status !== 6'h00) begin miscompares++; $display("FAIL sel0_write got ack=%b status=%h exp 1/00", got, status); end
        bus(1, BASE + 12, 32'hFFFF_FFFF, 4'hF, rd, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rsvd_write got ack=%b exp 1", got); end
        bus(0, BASE + 12, 32'h0, 4'hF, rd, got);
        vectors++; if (got !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL rsvd_read got ack=%b dat=%h exp 1/0", got, rd); end
        bus(0, BASE + 8, 32'h0, 4'hF, rd, got);
        vectors++; if (rd !== 32'h1 || status !== 6'h00) begin miscompares++; $display("FAIL ctrl_read got %h status=%h exp 1/00", rd, status); end
        bus(1, BASE + 32'h10, 32'd9, 4'hF, rd, got);
        vectors++; if (got !== 1'b0) begin miscompares++; $display("FAIL unmapped_ack got %b exp 0", got); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic got;
        do_reset();
        bus(1, BASE + 8, 32'h1, 4'hF, rd, got);
        bus(1, BASE, 32'd12, 4'hF, rd, got);
        repeat (10) @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE; wdat = 32'd5; sel = 4'hF;
        #2 rst = 1;
        #1;
        vectors++; if (status !== 6'h00 || oeb !== 6'h3F || ack !== 1'b0) begin
            miscompares++; $display("FAIL abort_now got status=%h oeb=%h ack=%b exp 00/3f/0", status, oeb, ack);
        end
        @(negedge clk);
        vectors++; if (ack !== 1'b0 || dat_o !== 32'h0) begin miscompares++; $display("FAIL abort_ack got ack=%b dat=%h exp 0/0", ack, dat_o); end
        cyc = 0; stb = 0; we = 0; rst = 0;
        repeat (5) @(negedge clk);
        vectors++; if (status !== 6'h00) begin miscompares++; $display("FAIL abort_after got %h exp 00", status); end
    endtask

    task automatic test_random();
        int held, k;
        do_reset();
        held = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            vectors++; if (status !== m_status) begin miscompares++; $display("FAIL rnd_status[%0d] got %h exp %h", i, status, m_status); end
            vectors++; if (oeb !== m_oeb) begin miscompares++; $display("FAIL rnd_oeb[%0d] got %h exp %h", i, oeb, m_oeb); end
            vectors++; if (ack !== m_ack) begin miscompares++; $display("FAIL rnd_ack[%0d] got %b exp %b", i, ack, m_ack); end
            if (m_ack) begin
                vectors++; if (dat_o !== m_dat) begin miscompares++; $display("FAIL rnd_dat[%0d] got %h exp %h", i, dat_o, m_dat); end
            end
            rst = (i == 1500);
            if (rst || (cyc && (ack || held >= 3))) begin
                cyc = 0; stb = 0; we = 0;
            end else if (cyc) begin
                held++;
            end else if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 9);
                held = 1; cyc = 1; stb = 1;
                sel = $urandom_range(0, 7) == 0 ? 4'($urandom) & 4'hE : 4'hF;
                we = k < 7 || k == 8;
                wdat = $urandom;
                case (k)
                    0, 1, 2, 3, 4: adr = BASE;
                    5: adr = BASE + 4;
                    6: begin
                        adr = BASE + 8;
                        wdat[0] = $urandom_range(0, 3) != 0;
                        wdat[1] = $urandom_range(0, 7) == 0;
                    end
                    7: begin
                        adr = BASE + 32'($urandom_range(0, 3) * 4);
                        we = 0;
                    end
                    default: adr = BASE + 32'h100;
                endcase
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_hold_timing();
        test_overflow();
        test_error();
        test_flush();
        test_bus_misc();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
